id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 46 ++++
 rtl/id_ex_stage_forward_unit.sv | 19 +
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX pipeline stage: forward selects, result
// source codes and the ALU operation codes carried through this stage.
package id_ex_stage_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLTU   = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;
    localparam logic [3:0] ALU_LUI    = 4'b1001;
    localparam logic [3:0] ALU_NOP    = 4'b1010;
    localparam logic [3:0] ALU_SRA    = 4'b1011;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    // The memory stage holds the younger result, so it is checked first;
    // x0 is hard-wired zero and must never be forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forward-select generation for the execute stage, driven by the
// registered source addresses and the M/W destination writes.
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic       RegWriteM,
    input  logic [4:0] RdW,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    assign ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle operand forwarding and ALU source
// selection; flush and reset both load a zeroed bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  FlushE,
    input  logic                  StallE,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            RdD,
    input  logic                  RegWriteD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcAD,
    input  logic                  ALUSrcBD,
    input  logic [1:0]            ResultSrcD,
    input  logic [3:0]            ALUControlD,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [4:0]            RdM,
    input  logic                  RegWriteM,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [4:0]            RdW,
    input  logic                  RegWriteW,
    output logic [DATA_WIDTH-1:0] SrcAE,
    output logic [DATA_WIDTH-1:0] SrcBE,
    output logic [3:0]            ALUControlE,
    output logic [DATA_WIDTH-1:0] WriteDataE,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [4:0]            RdE,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic                  RegWriteE,
    output logic                  MemWriteE,
    output logic                  JumpE,
    output logic                  BranchE,
    output logic                  ValidE,
    output logic [1:0]            ResultSrcE
);

    logic [DATA_WIDTH-1:0] rd1_p1, rd2_p1, pc_p1, imm_p1;
    logic [4:0]            rs1_p1, rs2_p1, rd_p1;
    logic                  reg_write_p1, mem_write_p1, jump_p1, branch_p1;
    logic                  alu_src_a_p1, alu_src_b_p1, vld_p1;
    logic [1:0]            result_src_p1;
    logic [3:0]            alu_ctrl_p1;

    // ---- D -> E stage boundary ----
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            rd1_p1        <= '0;
            rd2_p1        <= '0;
            pc_p1         <= '0;
            imm_p1        <= '0;
            rs1_p1        <= 5'd0;
            rs2_p1        <= 5'd0;
            rd_p1         <= 5'd0;
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            jump_p1       <= 1'b0;
            branch_p1     <= 1'b0;
            alu_src_a_p1  <= 1'b0;
            alu_src_b_p1  <= 1'b0;
            result_src_p1 <= RESULT_ALU;
            alu_ctrl_p1   <= ALU_ADD;
            vld_p1        <= 1'b0;
        end else if (!StallE) begin
            rd1_p1        <= RD1D;
            rd2_p1        <= RD2D;
            pc_p1         <= PCD;
            imm_p1        <= ImmExtD;
            rs1_p1        <= Rs1D;
            rs2_p1        <= Rs2D;
            rd_p1         <= RdD;
            reg_write_p1  <= RegWriteD;
            mem_write_p1  <= MemWriteD;
            jump_p1       <= JumpD;
            branch_p1     <= BranchD;
            alu_src_a_p1  <= ALUSrcAD;
            alu_src_b_p1  <= ALUSrcBD;
            result_src_p1 <= ResultSrcD;
            alu_ctrl_p1   <= ALUControlD;
            vld_p1        <= 1'b1;
        end
    end

    logic [1:0] fwd_a, fwd_b;

    forward_unit u_forward_unit (
        .Rs1E      (rs1_p1),
        .Rs2E      (rs2_p1),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    // ---- E stage: forwarding and ALU source muxes ----
    logic [DATA_WIDTH-1:0] fwd_a_data, fwd_b_data;

    always_comb begin
        fwd_a_data = rd1_p1;
        case (fwd_a)
            FWD_M:   fwd_a_data = ALUResultM;
            FWD_W:   fwd_a_data = ResultW;
            default: fwd_a_data = rd1_p1;
        endcase
    end

    always_comb begin
        fwd_b_data = rd2_p1;
        case (fwd_b)
            FWD_M:   fwd_b_data = ALUResultM;
            FWD_W:   fwd_b_data = ResultW;
            default: fwd_b_data = rd2_p1;
        endcase
    end

    assign SrcAE       = alu_src_a_p1 ? pc_p1  : fwd_a_data;
    assign SrcBE       = alu_src_b_p1 ? imm_p1 : fwd_b_data;
    assign WriteDataE  = fwd_b_data;
    assign ALUControlE = alu_ctrl_p1;
    assign PCE         = pc_p1;
    assign ImmExtE     = imm_p1;
    assign RdE         = rd_p1;
    assign Rs1E        = rs1_p1;
    assign Rs2E        = rs2_p1;
    assign RegWriteE   = reg_write_p1;
    assign MemWriteE   = mem_write_p1;
    assign JumpE       = jump_p1;
    assign BranchE     = branch_p1;
    assign ValidE      = vld_p1;
    assign ResultSrcE  = result_src_p1;

endmodule
